// File: rtl/aes_encipher_core.sv
// Iterative AES-128/256 encipher datapath, one round per clock.
// Round keys are read combinationally from the key expander via Addr.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h00;
    b = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inverse as a^254 = a^2 * a^4 * ... * a^128
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_encipher_core #(
  parameter int NB_SBOX = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   Nk,
  input  logic         key_valid,
  input  logic         start,
  input  logic [127:0] block_in,
  output logic [3:0]   Addr,
  input  logic [127:0] ex_key,
  output logic         ready,
  output logic [127:0] block_out,
  output logic         out_valid,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   nr_q, nr_d;
  logic [127:0] state_q, state_d;
  logic [127:0] bo_q, bo_d;
  logic         ov_q, ov_d;
  logic         err_q, err_d;

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;

  for (genvar g = 0; g < NB_SBOX; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (state_q[127-8*g -: 8]),
      .y (sb[127-8*g -: 8])
    );
  end

  // byte r+4c is row r, column c; row r rotates left by r
  always_comb begin
    sr = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    nr_d    = nr_q;
    state_d = state_q;
    bo_d    = bo_q;
    ov_d    = 1'b0;
    err_d   = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (start && key_valid) begin
          if (Nk == 4'h3 || Nk == 4'h7) begin
            state_d = block_in ^ ex_key;
            nr_d    = (Nk == 4'h7) ? 4'd14 : 4'd10;
            rnd_d   = 4'd1;
            fsm_d   = ROUND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ROUND: begin
        state_d = mc ^ ex_key;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == nr_q - 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        bo_d  = sr ^ ex_key;
        ov_d  = 1'b1;
        rnd_d = 4'd0;
        fsm_d = IDLE;
      end
      default: begin
        rnd_d = 4'd0;
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      rnd_q   <= 4'd0;
      nr_q    <= 4'd0;
      state_q <= '0;
      bo_q    <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      nr_q    <= nr_d;
      state_q <= state_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

  assign Addr      = rnd_q;
  assign ready     = (fsm_q == IDLE);
  assign block_out = bo_q;
  assign out_valid = ov_q;
  assign err       = err_q;
endmodule

// File: tb/tb_aes_encipher_core.sv
// Bench for aes_encipher_core: FIPS-197 vectors against a byte-level
// AES model plus a cycle-level expectation tracker.
module tb_aes_encipher_core;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   Nk;
  logic         key_valid;
  logic         start;
  logic [127:0] block_in;
  logic [3:0]   Addr;
  logic [127:0] ex_key;
  logic         ready;
  logic [127:0] block_out;
  logic         out_valid;
  logic         err;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  logic [127:0] rk [16];
  logic [7:0]   sbox_t [256];
  int           hits [16];

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KB = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  assign ex_key = rk[Addr];

  aes_encipher_core #(.NB_SBOX(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .Nk        (Nk),
    .key_valid (key_valid),
    .start     (start),
    .block_in  (block_in),
    .Addr      (Addr),
    .ex_key    (ex_key),
    .ready     (ready),
    .block_out (block_out),
    .out_valid (out_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] v, y, cc;
    cc = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int z = 1; z < 256; z++)
        if (gm(8'(x), 8'(z)) == 8'h01) v = 8'(z);
      for (int i = 0; i < 8; i++)
        y[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ cc[i];
      sbox_t[x] = y;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
          s[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // cycle-level expectation: busy counts remaining edges until the result
  int           busy = 0;
  int           pnr = 0;
  logic [127:0] pct = '0;
  logic [127:0] e_bo = '0;
  logic         e_ov = 1'b0;
  logic         e_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      busy  <= 0;
      e_ov  <= 1'b0;
      e_err <= 1'b0;
      e_bo  <= '0;
    end else begin
      e_ov  <= 1'b0;
      e_err <= 1'b0;
      if (busy > 0) begin
        busy <= busy - 1;
        if (busy == 1) begin
          e_ov <= 1'b1;
          e_bo <= pct;
        end
      end else if (start && key_valid) begin
        if (Nk == 4'h3 || Nk == 4'h7) begin
          pnr  <= (Nk == 4'h7) ? 14 : 10;
          busy <= (Nk == 4'h7) ? 14 : 10;
          pct  <= aes_enc(block_in, (Nk == 4'h7) ? 14 : 10);
        end else begin
          e_err <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 128'(ready), 128'(busy == 0));
      chk("addr", 128'(Addr), (busy == 0) ? 128'h0 : 128'(pnr - busy + 1));
      chk("out_valid", 128'(out_valid), 128'(e_ov));
      chk("err", 128'(err), 128'(e_err));
      chk("block_out", block_out, e_bo);
    end
  end

  task automatic wait_ov(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      if (!out_valid) hits[Addr]++;
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic run_one(input logic [127:0] pt, input logic [127:0] exp,
                         input int nr, input string nm);
    int cnt;
    for (int i = 0; i < 16; i++) hits[i] = 0;
    start = 1'b1;
    block_in = pt;
    hits[Addr]++;
    @(negedge clk);
    start = 1'b0;
    wait_ov(cnt);
    chk({nm, "_latency"}, 128'(cnt), 128'(nr));
    chk({nm, "_value"}, block_out, exp);
  endtask

  initial begin
    int cnt;
    int ovs;
    bit ok;
    rst = 1'b1;
    start = 1'b0;
    key_valid = 1'b0;
    Nk = 4'h0;
    block_in = '0;
    init_sbox();
    expand(K1, 4);
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(ready), 128'h1);
    chk("rst_addr", 128'(Addr), 128'h0);
    chk("rst_ov", 128'(out_valid), 128'h0);
    chk("rst_err", 128'(err), 128'h0);
    chk("rst_bo", block_out, 128'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    expand(K1, 4);
    chk("model_c1", aes_enc(PT1, 10), CT1);
    key_valid = 1'b1;
    Nk = 4'h3;
    run_one(PT1, CT1, 10, "c1");

    expand(K3, 8);
    chk("model_c3", aes_enc(PT1, 14), CT3);
    Nk = 4'h7;
    run_one(PT1, CT3, 14, "c3");
    ok = 1'b1;
    for (int i = 0; i < 15; i++) if (hits[i] != 1) ok = 1'b0;
    chk("c3_addr_steps", 128'(ok), 128'h1);

    @(negedge clk);
    expand(KB, 4);
    chk("model_b", aes_enc(PTB, 10), CTB);
    Nk = 4'h3;
    run_one(PTB, CTB, 10, "b2b_first");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_spacing", 128'(cnt), 128'd11);
    chk("b2b_second", block_out, CTB);

    @(negedge clk);
    Nk = 4'h5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("nk5_err", 128'(err), 128'h1);
    chk("nk5_ready", 128'(ready), 128'h1);
    ovs = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) ovs++;
    end
    chk("nk5_no_ov", 128'(ovs), 128'h0);

    Nk = 4'h3;
    key_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("kv0_err", 128'(err), 128'h0);
    chk("kv0_addr", 128'(Addr), 128'h0);
    @(negedge clk);
    chk("kv0_ready", 128'(ready), 128'h1);
    key_valid = 1'b1;

    expand(K1, 4);
    start = 1'b1;
    block_in = PT1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    block_in = ~PT1;
    Nk = 4'h7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    Nk = 4'h3;
    wait_ov(cnt);
    chk("busy_value", block_out, CT1);
    ovs = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) ovs++;
    end
    chk("busy_single", 128'(ovs), 128'h0);

    start = 1'b1;
    block_in = PT1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", 128'(ready), 128'h1);
    chk("mrst_addr", 128'(Addr), 128'h0);
    chk("mrst_ov", 128'(out_valid), 128'h0);
    chk("mrst_bo", block_out, 128'h0);
    ovs = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) ovs++;
    end
    chk("mrst_no_ov", 128'(ovs), 128'h0);
    run_one(PT1, CT1, 10, "post_rst");
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_encipher_core.md
# aes_encipher_core

Iterative AES encryption datapath that sits directly downstream of the key-expansion stage. It reads one 128-bit round key per cycle through the expander's combinational address/data read port. It computes one full cipher round per clock, then returns the 128-bit ciphertext with a one-cycle valid pulse. It supports 128-bit and 256-bit keys. Other key sizes are rejected with an error pulse.

## Interface
Parameters:
- `NB_SBOX`, default 16, number of `aes_sbox` instances. The value is fixed at 16, giving one full state SubBytes per cycle.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset. The block has one clock. Reset is synchronous and active-high.
- `Nk`  in  4  key-size code, same encoding as the key expander:
  - 4'h3 = AES-128, Nr=10.
  - 4'h7 = AES-256, Nr=14.
  - Any other value is an error.
- `key_valid`  in  1  high while the expander's key memory holds a complete schedule.
- `start`  in  1  request to encrypt `block_in`. Sampled only when `ready`=1.
- `block_in`  in  128  plaintext. [127:120] is state byte 0, in FIPS-197 column-major order.
- `Addr`  out  4  round-key address driven to the expander.
- `ex_key`  in  128  round key at `Addr`, combinational from the expander. w0 is at [127:96].
- `ready`  out  1  idle, able to accept `start`.
- `block_out`  out  128  ciphertext, held until the next completion.
- `out_valid`  out  1  one-cycle pulse when `block_out` updates.
- `err`  out  1  one-cycle pulse on a rejected start.

## Operation
- State register `state[127:0]`, round counter `rnd[3:0]`, latched round limit `nr[3:0]`.
- `Addr` = `rnd` in every state. `rnd` = 0 in IDLE.
- FSM has three states: IDLE, ROUND, FINAL.
- **IDLE** (`ready`=1). Each cycle, if `start`=1:
  - If `key_valid`=1 and `Nk`∈{3,7}: `state` <= `block_in` ^ `ex_key` (Addr 0, initial AddRoundKey); `nr` <= 10 or 14; `rnd` <= 1; go to ROUND.
  - If `key_valid`=0: the start is ignored silently.
  - If `key_valid`=1 and `Nk` is illegal: `err` pulses the next cycle, and the block stays in IDLE.
- **ROUND**:
  - `state` <= MixColumns(ShiftRows(SubBytes(state))) ^ `ex_key`.
  - `rnd` <= `rnd`+1.
  - When `rnd` = `nr`-1, go to FINAL.
- **FINAL**:
  - `block_out` <= ShiftRows(SubBytes(state)) ^ `ex_key` (Addr = `nr`).
  - `out_valid` <= 1 for one cycle.
  - `rnd` <= 0; go to IDLE.
- MixColumns uses xtime(b) = {b[6:0],1'b0} ^ (8'h1b & {8{b[7]}}), over GF(2^8), with 8-bit byte-wise arithmetic.
- `Nk` and `key_valid` are ignored after start. The round limit is the latched `nr`. The schedule must not change mid-operation; that is the system controller's responsibility.
- `start` outside IDLE is ignored and is not queued.

## Timing
- Reset values:
  - FSM = IDLE.
  - `rnd` = 0, `nr` = 0.
  - `state` = 0, `block_out` = 0.
  - `out_valid` = 0, `err` = 0.
  - `ready` = 1 (combinational from FSM).
  - `Addr` = 0.
- Reset asserted mid-operation aborts on the next edge. `out_valid` does not pulse for the aborted block.
- Latency: start accepted at edge E0, then rounds 1..Nr-1 at edges E1..E(Nr-1), then the final round at E(Nr).
  - `block_out` and `out_valid` are valid after E(Nr): 10 cycles for AES-128, 14 cycles for AES-256.
- `ready` rises in the same cycle `out_valid` is high. A new `start` in that cycle is accepted, giving back-to-back throughput of one block per Nr+1 cycles.
- `Addr` → `ex_key` is a combinational path within one cycle. No key-prefetch register is used.
- `err` pulses exactly one cycle after the rejected `start` edge. `ready` stays 1 throughout.

## Test plan
- **AES-128, FIPS-197 C.1.** Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff. Required response: `block_out` = 69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` exactly 10 cycles after start.
- **AES-256, FIPS-197 C.3.** Key 000102…1e1f, same pt. Required response: 8ea2b7ca516745bfeafc49904b496089 after 14 cycles. `Addr` steps 0..14, once each.
- **Back-to-back.** FIPS-197 App. B, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734. Issue a second start in the `out_valid` cycle. Required response: both results 3925841d02dc09fbdc118597196a0b32, with two pulses 11 cycles apart.
- **Rejected starts.**
  - `Nk`=5 with `key_valid`=1: `err` pulses once, with no `out_valid` and `ready` held at 1.
  - `key_valid`=0: no `err`, no activity.
- **Ignored start while busy.** Pulse `start` with different data during ROUND. Required response: only the original block is produced, and `Nk` toggled mid-run has no effect.
- **Reset mid-run.** Assert `rst` at round 5. Required response: all outputs return to reset values next cycle, no `out_valid`, and a subsequent C.1 run gives the correct result.
